// File: rtl/enc4b5b_pkg.sv
// ============================================================================
// Package : enc4b5b_pkg
// Brief   : 4b/5b symbol codes, FSM state type and the nibble encode table
// Rev     : 1.0
// ============================================================================
`default_nettype none

package enc4b5b_pkg;

    localparam logic [4:0] SYM_IDLE = 5'b11100;
    localparam logic [4:0] SYM_SOF  = 5'b11000;
    localparam logic [4:0] SYM_EOF  = 5'b00111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_DATA = 3'd2,
        ST_FILL = 3'd3,
        ST_EOF  = 3'd4
    } state_t;

    function automatic logic [4:0] enc_nibble(input logic [3:0] i_nib);
        logic [4:0] w_code;
        case (i_nib)
            4'h0: w_code = 5'h04;
            4'h1: w_code = 5'h05;
            4'h2: w_code = 5'h06;
            4'h3: w_code = 5'h09;
            4'h4: w_code = 5'h0A;
            4'h5: w_code = 5'h0B;
            4'h6: w_code = 5'h0C;
            4'h7: w_code = 5'h0D;
            4'h8: w_code = 5'h12;
            4'h9: w_code = 5'h13;
            4'hA: w_code = 5'h14;
            4'hB: w_code = 5'h15;
            4'hC: w_code = 5'h16;
            4'hD: w_code = 5'h19;
            4'hE: w_code = 5'h1A;
            default: w_code = 5'h1B;
        endcase
        return w_code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/framed_encoder_4b_5b_serializer.sv
// ============================================================================
// Module : sym_serializer_5b
// Brief  : 5-bit symbol shifter; loads a new symbol every fifth cycle
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sym_serializer_5b
    import enc4b5b_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_load_sym,
    output logic       o_boundary,
    output logic       o_tx_bit,
    output logic       o_sym_start
);

    logic [4:0] r_shift;
    logic [2:0] r_bit_cnt;

    assign o_boundary  = (r_bit_cnt == 3'd4);
    assign o_sym_start = (r_bit_cnt == 3'd0);
    assign o_tx_bit    = MSB_FIRST ? r_shift[4] : r_shift[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= SYM_IDLE;
            r_bit_cnt <= 3'd0;
        end else if (o_boundary) begin
            r_shift   <= i_load_sym;
            r_bit_cnt <= 3'd0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= MSB_FIRST ? {r_shift[3:0], 1'b0} : {1'b0, r_shift[4:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/framed_encoder_4b_5b.sv
// ============================================================================
// Module : framed_encoder_4b_5b
// Brief  : Frames N-nibble words as SOF/data/EOF 4b5b symbols on a serial line
// Rev    : 1.0
// ============================================================================
`default_nettype none

module framed_encoder_4b_5b
    import enc4b5b_pkg::*;
#(
    parameter int NIBBLES   = 2,
    parameter bit LSN_FIRST = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NIBBLES-1:0]   s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   tx_bit,
    output logic                   sym_start,
    output logic                   in_frame,
    output logic                   underrun
);

    localparam int               DATA_W   = 4 * NIBBLES;
    localparam int               NIB_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NIB_W-1:0]   r_nib_cnt;
    logic [NIB_W-1:0]   w_nib_nxt;
    logic [NIB_W-1:0]   w_nib_idx;
    logic [DATA_W-1:0]  r_word;
    logic [DATA_W-1:0]  w_src_word;
    logic               r_last;
    logic               r_in_frame;
    logic               r_underrun;
    logic               w_boundary;
    logic               w_last_nib;
    logic               w_accept;
    logic [3:0]         w_nibble;
    logic [4:0]         w_sym;

    assign w_last_nib = (r_nib_cnt == NIB_LAST);
    assign s_ready    = w_boundary & ((r_state == ST_IDLE) | (r_state == ST_FILL) |
                        ((r_state == ST_DATA) & w_last_nib & ~r_last));
    assign w_accept   = s_valid & s_ready;
    // A word accepted mid-frame supplies its first nibble straight from the port.
    assign w_src_word = w_accept ? s_data : r_word;
    assign w_nib_idx  = LSN_FIRST ? w_nib_nxt : (NIB_LAST - w_nib_nxt);

    always_comb begin
        w_state_nxt = r_state;
        w_nib_nxt   = r_nib_cnt;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_SOF;
            ST_SOF: begin
                w_state_nxt = ST_DATA;
                w_nib_nxt   = '0;
            end
            ST_DATA: begin
                if (!w_last_nib) begin
                    w_nib_nxt = r_nib_cnt + NIB_W'(1);
                end else if (r_last) begin
                    w_state_nxt = ST_EOF;
                end else if (w_accept) begin
                    w_nib_nxt = '0;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    w_state_nxt = ST_DATA;
                    w_nib_nxt   = '0;
                end
            end
            ST_EOF:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (w_nib_idx == NIB_W'(i)) w_nibble = w_src_word[4*i +: 4];
        end
    end

    always_comb begin
        case (w_state_nxt)
            ST_SOF:  w_sym = SYM_SOF;
            ST_DATA: w_sym = enc_nibble(w_nibble);
            ST_EOF:  w_sym = SYM_EOF;
            default: w_sym = SYM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_nib_cnt  <= '0;
            r_word     <= '0;
            r_last     <= 1'b0;
            r_in_frame <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_accept) begin
                r_word <= s_data;
                r_last <= s_last;
            end
            if (w_boundary) begin
                r_state    <= w_state_nxt;
                r_nib_cnt  <= w_nib_nxt;
                r_in_frame <= (w_state_nxt != ST_IDLE);
                r_underrun <= (w_state_nxt == ST_FILL);
            end
        end
    end

    sym_serializer_5b #(
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_load_sym  (w_sym),
        .o_boundary  (w_boundary),
        .o_tx_bit    (tx_bit),
        .o_sym_start (sym_start)
    );

    assign in_frame = r_in_frame;
    assign underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_framed_encoder_4b_5b.sv
// ============================================================================
// Module : tb_framed_encoder_4b_5b
// Brief  : Scoreboard bench for three encoder configurations sharing one line clock
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_framed_encoder_4b_5b;

    localparam int NDUT = 3;
    localparam logic [4:0] C_IDLE = 5'b11100;
    localparam logic [4:0] C_SOF  = 5'b11000;
    localparam logic [4:0] C_EOF  = 5'b00111;
    localparam logic [4:0] ENC [16] = '{5'h04, 5'h05, 5'h06, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D,
                                        5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h19, 5'h1A, 5'h1B};

    // dut0: N=2 LSN-first MSB-first; dut1: N=1 LSB-first line; dut2: N=3 MSN-first
    function automatic int cfg_nib(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    endfunction
    function automatic bit cfg_lsn(input int g);
        return (g != 2);
    endfunction
    function automatic bit cfg_msb(input int g);
        return (g != 1);
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] s_data    [NDUT];
    logic        s_valid   [NDUT];
    logic        s_last    [NDUT];
    logic        s_ready   [NDUT];
    logic        tx_bit    [NDUT];
    logic        sym_start [NDUT];
    logic        in_frame  [NDUT];
    logic        underrun  [NDUT];

    logic [4:0]  exp_q [NDUT][$];
    int          lat_q [NDUT][$];
    bit          fr    [NDUT];
    int          fills [NDUT];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [11:0] wq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int g, input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", nm, g, cyc, act, exp_v);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int NB  = cfg_nib(g);
        localparam bit MSB = cfg_msb(g);

        framed_encoder_4b_5b #(
            .NIBBLES   (NB),
            .LSN_FIRST (cfg_lsn(g)),
            .MSB_FIRST (MSB)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .s_data    (s_data[g][4*NB-1:0]),
            .s_valid   (s_valid[g]),
            .s_last    (s_last[g]),
            .s_ready   (s_ready[g]),
            .tx_bit    (tx_bit[g]),
            .sym_start (sym_start[g]),
            .in_frame  (in_frame[g]),
            .underrun  (underrun[g])
        );

        int         phase = 0;
        int         sof_cyc = 0;
        logic [4:0] acc;
        logic       fr_in;
        logic       ur;
        bit         after_eof = 1'b0;

        // Reassemble each symbol from the line and classify it once complete.
        always @(negedge clk) begin
            if (rst) begin
                chk(g, "rst_tx_bit", tx_bit[g], MSB ? 1 : 0);
                chk(g, "rst_sym_start", sym_start[g], 1);
                chk(g, "rst_in_frame", in_frame[g], 0);
                chk(g, "rst_s_ready", s_ready[g], 0);
                chk(g, "rst_underrun", underrun[g], 0);
                phase     = 0;
                fr[g]     = 1'b0;
                after_eof = 1'b0;
                exp_q[g].delete();
                lat_q[g].delete();
            end else begin
                chk(g, "sym_start", sym_start[g], (phase == 0) ? 1 : 0);
                if (phase != 4) chk(g, "ready_off_boundary", s_ready[g], 0);
                if (phase == 0) begin
                    acc     = 5'b0;
                    sof_cyc = cyc;
                    fr_in   = in_frame[g];
                    ur      = underrun[g];
                end else begin
                    chk(g, "in_frame_stable", in_frame[g], fr_in);
                    chk(g, "underrun_width", underrun[g], 0);
                end
                if (MSB) acc[4-phase] = tx_bit[g];
                else     acc[phase]   = tx_bit[g];
                if (phase == 4) begin
                    if (!fr[g]) begin
                        if (acc == C_SOF) begin
                            chk(g, "idle_after_eof", after_eof, 0);
                            chk(g, "sof_in_frame", fr_in, 1);
                            chk(g, "sof_expected", (exp_q[g].size() > 0) ? 1 : 0, 1);
                            if (exp_q[g].size() > 0) chk(g, "sof_code", acc, exp_q[g].pop_front());
                            chk(g, "sof_latency_known", (lat_q[g].size() > 0) ? 1 : 0, 1);
                            if (lat_q[g].size() > 0) chk(g, "sof_latency", sof_cyc, lat_q[g].pop_front());
                            fr[g] = 1'b1;
                        end else begin
                            chk(g, "idle_code", acc, C_IDLE);
                            chk(g, "idle_in_frame", fr_in, 0);
                            chk(g, "idle_underrun", ur, 0);
                        end
                        after_eof = 1'b0;
                    end else begin
                        chk(g, "frame_in_frame", fr_in, 1);
                        if (acc == C_IDLE) begin
                            chk(g, "fill_underrun", ur, 1);
                            fills[g]++;
                        end else begin
                            chk(g, "sym_underrun", ur, 0);
                            chk(g, "sym_expected", (exp_q[g].size() > 0) ? 1 : 0, 1);
                            if (exp_q[g].size() > 0) chk(g, "sym_code", acc, exp_q[g].pop_front());
                            if (acc == C_EOF) begin
                                fr[g]     = 1'b0;
                                after_eof = 1'b1;
                            end
                        end
                    end
                end
                phase = (phase == 4) ? 0 : phase + 1;
            end
        end
    end

    task automatic drive_word(input int g, input logic [11:0] d, input bit l, input bit first);
        bit ok = 1'b0;
        s_data[g]  = d;
        s_last[g]  = l;
        s_valid[g] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_ready[g]) begin
                ok = 1'b1;
                if (first) lat_q[g].push_back(cyc + 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid[g] = 1'b0;
        chk(g, "accept_timeout", ok, 1);
    endtask

    // Expected line content: SOF, every nibble of every word in send order, EOF.
    task automatic send_frame(input int g, input logic [11:0] words[$], input int gap);
        int nb = cfg_nib(g);
        exp_q[g].push_back(C_SOF);
        foreach (words[w]) begin
            for (int n = 0; n < nb; n++) begin
                int         idx = cfg_lsn(g) ? n : nb - 1 - n;
                logic [3:0] nib = 4'(words[w] >> (4 * idx));
                exp_q[g].push_back(ENC[nib]);
            end
        end
        exp_q[g].push_back(C_EOF);
        foreach (words[w]) begin
            if (w > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            drive_word(g, words[w], (w == words.size() - 1), (w == 0));
        end
    endtask

    task automatic wait_drain(input int g);
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q[g].size() == 0 && !fr[g]) begin
                done = 1'b1;
                break;
            end
        end
        chk(g, "drain_timeout", done, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int f0;
        rst = 1'b1;
        for (int g = 0; g < NDUT; g++) begin
            s_data[g]  = '0;
            s_valid[g] = 1'b0;
            s_last[g]  = 1'b0;
            fills[g]   = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        wq.delete(); wq.push_back(12'h03A);
        f0 = fills[0];
        send_frame(0, wq, 0);
        wait_drain(0);
        chk(0, "fills_single_word", fills[0] - f0, 0);

        wq.delete(); wq.push_back(12'h021); wq.push_back(12'h00F);
        f0 = fills[0];
        send_frame(0, wq, 0);
        wait_drain(0);
        chk(0, "fills_valid_held", fills[0] - f0, 0);

        // Next word valid after edge +27: decisions at +15, +20, +25 find nothing.
        f0 = fills[0];
        send_frame(0, wq, 27);
        wait_drain(0);
        chk(0, "fills_delayed_word", fills[0] - f0, 3);

        exp_q[0].push_back(C_SOF);
        exp_q[0].push_back(ENC[12]);
        exp_q[0].push_back(ENC[5]);
        exp_q[0].push_back(C_EOF);
        drive_word(0, 12'h05C, 1'b1, 1'b1);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk(0, "abort_tx_bit", tx_bit[0], 1);
        chk(0, "abort_in_frame", in_frame[0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        wq.delete(); wq.push_back(12'h03A);
        send_frame(0, wq, 0);
        wait_drain(0);

        wq.delete(); wq.push_back(12'h008);
        send_frame(1, wq, 0);
        wait_drain(1);

        for (int g = 0; g < NDUT; g++) begin
            for (int f = 0; f < 6; f++) begin
                int nw = int'($urandom_range(1, 3));
                int nb = cfg_nib(g);
                wq.delete();
                for (int w = 0; w < nw; w++) wq.push_back(12'($urandom()));
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                send_frame(g, wq, int'($urandom_range(0, 10 * nb + 8)));
                wait_drain(g);
            end
        end

        for (int g = 0; g < NDUT; g++) begin
            chk(g, "queue_drained", exp_q[g].size(), 0);
            chk(g, "latency_drained", lat_q[g].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
